// File: rtl/mips_stats_pkg.sv
// rtl/mips_stats_pkg.sv - shared encodings for the instruction statistics block
//
// Purpose: read-select codes, FSM state encoding, default counter width and a
// small helper used to classify the r/i/j flag combination.
package mips_stats_pkg;

  localparam int CNT_W_DEFAULT = 32;
  localparam int NUM_CNT       = 6;

  // rd_sel encodings; the same values index the counter array
  localparam logic [2:0] SEL_TOTAL = 3'd0;
  localparam logic [2:0] SEL_R     = 3'd1;
  localparam logic [2:0] SEL_I     = 3'd2;
  localparam logic [2:0] SEL_J     = 3'd3;
  localparam logic [2:0] SEL_UNK   = 3'd4;
  localparam logic [2:0] SEL_ILL   = 3'd5;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } stats_state_t;

  // number of classifier flags asserted (0..3)
  function automatic logic [1:0] flag_count(input logic r, input logic i, input logic j);
    return {1'b0, r} + {1'b0, i} + {1'b0, j};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   clr  - synchronous clear
//   inc  - increment request; ignored once q is all ones
//   q    - counter value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/instr_type_stats.sv
// rtl/instr_type_stats.sv - retired-instruction counts by R/I/J format
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   retire            - one instruction retires this cycle
//   i, r, j           - classifier format flags, sampled only with retire
//   halt              - CPU halted; freezes the counters
//   clr               - synchronous clear of counters/err, returns to RUN
//   rd_en, rd_sel     - read request and counter select
//   rd_data, rd_valid - registered read result, one cycle after rd_en
//   frozen            - high while frozen
//   err               - sticky: an illegal flag combination was counted
module instr_type_stats
  import mips_stats_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  input  logic             i,
  input  logic             r,
  input  logic             j,
  input  logic             halt,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             frozen,
  output logic             err
);

  stats_state_t     state;
  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic [NUM_CNT-1:0] inc;
  logic [1:0]       nflags;
  logic             count_en;
  logic [CNT_W-1:0] rd_mux;

  // halt and clr both take precedence over a retire in the same cycle
  assign count_en = (state == ST_RUN) && retire && !clr && !halt;
  assign nflags   = flag_count(r, i, j);

  always_comb begin
    inc            = '0;
    inc[SEL_TOTAL] = count_en;
    inc[SEL_R]     = count_en && (nflags == 2'd1) && r;
    inc[SEL_I]     = count_en && (nflags == 2'd1) && i;
    inc[SEL_J]     = count_en && (nflags == 2'd1) && j;
    inc[SEL_UNK]   = count_en && (nflags == 2'd0);
    inc[SEL_ILL]   = count_en && (nflags >= 2'd2);
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (inc[k]),
      .q   (cnt_q[k])
    );
  end

  // reads see the counters as they stand before this edge's update
  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      SEL_TOTAL: rd_mux = cnt_q[SEL_TOTAL];
      SEL_R:     rd_mux = cnt_q[SEL_R];
      SEL_I:     rd_mux = cnt_q[SEL_I];
      SEL_J:     rd_mux = cnt_q[SEL_J];
      SEL_UNK:   rd_mux = cnt_q[SEL_UNK];
      SEL_ILL:   rd_mux = cnt_q[SEL_ILL];
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      frozen   <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_mux;
      end
      if (clr) begin
        state  <= ST_RUN;
        frozen <= 1'b0;
        err    <= 1'b0;
      end else begin
        // frozen tracks the next state so it is aligned with state itself
        if ((state == ST_RUN) && halt) begin
          state  <= ST_FROZEN;
          frozen <= 1'b1;
        end
        if (inc[SEL_ILL]) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_type_stats.sv
// tb/tb_instr_type_stats.sv - self-checking bench for instr_type_stats
module tb_instr_type_stats;

  logic        clk = 1'b0;
  logic        rst, retire, i, r, j, halt, clr, rd_en;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data_a;
  logic [3:0]  rd_data_b;
  logic        rd_valid_a, rd_valid_b, frozen_a, frozen_b, err_a, err_b;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: unbounded raw counts, saturation applied on read-out
  longint cnt [6];
  bit     m_frozen, m_err, m_rv;
  longint m_rd_a, m_rd_b;

  always #5 clk = ~clk;

  instr_type_stats #(.CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .retire(retire), .i(i), .r(r), .j(j),
    .halt(halt), .clr(clr), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .frozen(frozen_a), .err(err_a)
  );

  instr_type_stats #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .retire(retire), .i(i), .r(r), .j(j),
    .halt(halt), .clr(clr), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .frozen(frozen_b), .err(err_b)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_edge(input bit rst_i, retire_i, r_i, i_i, j_i, halt_i, clr_i,
                            rd_en_i, input int sel_i);
    int nf;
    if (rst_i) begin
      foreach (cnt[k]) cnt[k] = 0;
      m_frozen = 0; m_err = 0; m_rv = 0; m_rd_a = 0; m_rd_b = 0;
      return;
    end
    m_rv = rd_en_i;
    if (rd_en_i) begin
      m_rd_a = (sel_i < 6) ? sat(cnt[sel_i], 64'hFFFF_FFFF) : 0;
      m_rd_b = (sel_i < 6) ? sat(cnt[sel_i], 15) : 0;
    end
    if (clr_i) begin
      foreach (cnt[k]) cnt[k] = 0;
      m_frozen = 0; m_err = 0;
    end else if (!m_frozen) begin
      if (halt_i) begin
        m_frozen = 1;
      end else if (retire_i) begin
        cnt[0]++;
        nf = int'(r_i) + int'(i_i) + int'(j_i);
        if (nf == 0)      cnt[4]++;
        else if (nf > 1)  begin cnt[5]++; m_err = 1; end
        else if (r_i)     cnt[1]++;
        else if (i_i)     cnt[2]++;
        else              cnt[3]++;
      end
    end
  endtask

  task automatic step(input bit rst_i, retire_i, r_i, i_i, j_i, halt_i, clr_i,
                      rd_en_i, input int sel_i);
    rst = rst_i; retire = retire_i; r = r_i; i = i_i; j = j_i;
    halt = halt_i; clr = clr_i; rd_en = rd_en_i; rd_sel = 3'(sel_i);
    @(posedge clk);
    model_edge(rst_i, retire_i, r_i, i_i, j_i, halt_i, clr_i, rd_en_i, sel_i);
    #1;
    check("rd_valid_a", rd_valid_a, m_rv);
    check("rd_valid_b", rd_valid_b, m_rv);
    check("rd_data_a", rd_data_a, m_rd_a);
    check("rd_data_b", rd_data_b, m_rd_b);
    check("frozen_a", frozen_a, m_frozen);
    check("frozen_b", frozen_b, m_frozen);
    check("err_a", err_a, m_err);
    check("err_b", err_b, m_err);
  endtask

  task automatic retire_rij(input bit r_i, i_i, j_i);
    step(0, 1, r_i, i_i, j_i, 0, 0, 0, 0);
  endtask

  task automatic rd(input int sel_i);
    step(0, 0, 0, 0, 0, 0, 0, 1, sel_i);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int exp_cnt [6];
    exp_cnt = '{6, 1, 2, 1, 1, 1};

    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_rd_data", rd_data_a, 0);
    check("reset_frozen", frozen_a, 0);

    // mixed formats, one per cycle
    retire_rij(1, 0, 0);
    retire_rij(0, 1, 0);
    retire_rij(0, 1, 0);
    retire_rij(0, 0, 1);
    retire_rij(0, 0, 0);
    retire_rij(1, 1, 0);
    for (int s = 0; s < 6; s++) begin
      rd(s);
      check($sformatf("mix_sel%0d", s), rd_data_a, exp_cnt[s]);
      check("mix_valid", rd_valid_a, 1);
    end
    check("mix_err", err_a, 1);
    idle();
    check("valid_drops", rd_valid_a, 0);
    check("rd_data_holds", rd_data_a, 1);

    // halt with a coincident retire freezes the counts
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) retire_rij(0, 1, 0);
    step(0, 1, 0, 1, 0, 1, 0, 0, 0);
    check("halt_frozen", frozen_a, 1);
    repeat (2) retire_rij(0, 1, 0);
    rd(2); check("frozen_I", rd_data_a, 3);
    rd(0); check("frozen_total", rd_data_a, 3);

    // clr in FROZEN wins over a retire, then counting resumes
    step(0, 1, 0, 0, 1, 0, 1, 0, 0);
    retire_rij(0, 0, 1);
    rd(3); check("clr_J", rd_data_a, 1);
    rd(0); check("clr_total", rd_data_a, 1);
    check("clr_frozen", frozen_a, 0);
    check("clr_err", err_a, 0);

    // saturation on the narrow instance
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (17) retire_rij(1, 0, 0);
    rd(1); check("sat_R_b", rd_data_b, 15);
    rd(0); check("sat_total_b", rd_data_b, 15);
    check("sat_total_a", rd_data_a, 17);

    // read coincident with an update returns the pre-update value
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (5) retire_rij(1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 1, 1);
    check("rd_pre_update", rd_data_a, 5);
    rd(1); check("rd_post_update", rd_data_a, 6);
    rd(7); check("reserved_sel", rd_data_a, 0);
    check("reserved_valid", rd_valid_a, 1);
    // read with clr returns pre-clear value
    step(0, 0, 0, 0, 0, 0, 1, 1, 1);
    check("rd_pre_clear", rd_data_a, 6);

    // reset mid-stream while frozen with non-zero counts
    repeat (4) retire_rij(0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("pre_rst_frozen", frozen_a, 1);
    step(1, 1, 1, 0, 0, 1, 1, 1, 0);
    check("rst_frozen", frozen_a, 0);
    check("rst_err", err_a, 0);
    for (int s = 0; s < 6; s++) begin
      rd(s);
      check($sformatf("rst_sel%0d", s), rd_data_a, 0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) < 7),
           1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 59) == 0),
           1'($urandom),
           int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
